// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - EX/MEM pipeline register with data-memory access controller
module mem_stage #(
  parameter int XLEN    = 32,
  parameter int REGADDR = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               EX_valid,
  input  logic [XLEN-1:0]    EX_pc,
  input  logic [XLEN-1:0]    EX_alu_out,
  input  logic [XLEN-1:0]    EX_rs2_out,
  input  logic [REGADDR-1:0] EX_rd,
  input  logic [2:0]         EX_funct3,
  input  logic               EX_mem_read,
  input  logic               EX_mem_write,
  input  logic               EX_regwrite,
  input  logic [XLEN-1:0]    dmem_rdata,
  input  logic               dmem_resp,
  output logic               dmem_read,
  output logic               dmem_write,
  output logic [XLEN-1:0]    dmem_address,
  output logic [XLEN-1:0]    dmem_wdata,
  output logic [3:0]         dmem_byte_enable,
  output logic               MEM_valid,
  output logic [XLEN-1:0]    MEM_pc,
  output logic [XLEN-1:0]    MEM_alu_out,
  output logic [REGADDR-1:0] MEM_rd,
  output logic               MEM_regwrite,
  output logic [XLEN-1:0]    MEM_load_data,
  output logic               MEM_misaligned,
  output logic               MEM_stall
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t            state;
  logic [XLEN-1:0]   mem_rs2;
  logic [2:0]        mem_funct3;
  logic              mem_read_q;
  logic              mem_write_q;

  logic              capture;
  logic              ex_access;
  logic              ex_misaligned;
  logic [1:0]        lane;
  logic [XLEN-1:0]   byte_src;
  logic [XLEN-1:0]   half_src;
  logic [XLEN-1:0]   load_ext;

  assign capture   = load && (state != ACCESS);
  assign ex_access = EX_valid && (EX_mem_read || EX_mem_write);
  assign lane      = MEM_alu_out[1:0];

  // Byte accesses never trap; word check only applies to funct3 010.
  always_comb begin
    ex_misaligned = 1'b0;
    case (EX_funct3)
      3'b001, 3'b101: ex_misaligned = EX_alu_out[0];
      3'b010:         ex_misaligned = |EX_alu_out[1:0];
      default:        ex_misaligned = 1'b0;
    endcase
  end

  assign MEM_stall    = (state == ACCESS);
  assign dmem_read    = (state == ACCESS) && mem_read_q;
  assign dmem_write   = (state == ACCESS) && mem_write_q;
  assign dmem_address = {MEM_alu_out[XLEN-1:2], 2'b00};

  always_comb begin
    dmem_byte_enable = 4'b0000;
    dmem_wdata       = mem_rs2;
    case (mem_funct3[1:0])
      2'b00: begin
        dmem_wdata = {4{mem_rs2[7:0]}};
        if (dmem_write) dmem_byte_enable = 4'b0001 << lane;
      end
      2'b01: begin
        dmem_wdata = {2{mem_rs2[15:0]}};
        if (dmem_write) dmem_byte_enable = lane[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        dmem_wdata = mem_rs2;
        if (dmem_write) dmem_byte_enable = 4'b1111;
      end
    endcase
  end

  assign byte_src = dmem_rdata >> {lane, 3'b000};
  assign half_src = dmem_rdata >> {lane[1], 4'b0000};

  always_comb begin
    load_ext = '0;
    if (mem_read_q) begin
      case (mem_funct3)
        3'b000:  load_ext = {{(XLEN-8){byte_src[7]}}, byte_src[7:0]};
        3'b100:  load_ext = {{(XLEN-8){1'b0}}, byte_src[7:0]};
        3'b001:  load_ext = {{(XLEN-16){half_src[15]}}, half_src[15:0]};
        3'b101:  load_ext = {{(XLEN-16){1'b0}}, half_src[15:0]};
        default: load_ext = dmem_rdata;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      MEM_valid      <= 1'b0;
      MEM_pc         <= '0;
      MEM_alu_out    <= '0;
      MEM_rd         <= '0;
      MEM_regwrite   <= 1'b0;
      MEM_load_data  <= '0;
      MEM_misaligned <= 1'b0;
      mem_rs2        <= '0;
      mem_funct3     <= 3'b000;
      mem_read_q     <= 1'b0;
      mem_write_q    <= 1'b0;
    end else if (capture) begin
      MEM_valid      <= EX_valid;
      MEM_pc         <= EX_pc;
      MEM_alu_out    <= EX_alu_out;
      MEM_rd         <= EX_rd;
      MEM_regwrite   <= EX_valid && EX_regwrite && !(ex_access && ex_misaligned);
      MEM_misaligned <= ex_access && ex_misaligned;
      MEM_load_data  <= '0;
      mem_rs2        <= EX_rs2_out;
      mem_funct3     <= EX_funct3;
      mem_read_q     <= EX_mem_read;
      mem_write_q    <= EX_mem_write;
      state          <= (ex_access && !ex_misaligned) ? ACCESS : IDLE;
    end else if (state == ACCESS && dmem_resp) begin
      MEM_load_data  <= load_ext;
      state          <= DONE;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - scoreboard bench for mem_stage
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        load;
  logic        EX_valid;
  logic [31:0] EX_pc, EX_alu_out, EX_rs2_out;
  logic [4:0]  EX_rd;
  logic [2:0]  EX_funct3;
  logic        EX_mem_read, EX_mem_write, EX_regwrite;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;
  logic        dmem_read, dmem_write;
  logic [31:0] dmem_address, dmem_wdata;
  logic [3:0]  dmem_byte_enable;
  logic        MEM_valid;
  logic [31:0] MEM_pc, MEM_alu_out;
  logic [4:0]  MEM_rd;
  logic        MEM_regwrite;
  logic [31:0] MEM_load_data;
  logic        MEM_misaligned, MEM_stall;

  mem_stage dut (
    .clk(clk), .reset(reset), .load(load), .EX_valid(EX_valid), .EX_pc(EX_pc),
    .EX_alu_out(EX_alu_out), .EX_rs2_out(EX_rs2_out), .EX_rd(EX_rd), .EX_funct3(EX_funct3),
    .EX_mem_read(EX_mem_read), .EX_mem_write(EX_mem_write), .EX_regwrite(EX_regwrite),
    .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp), .dmem_read(dmem_read),
    .dmem_write(dmem_write), .dmem_address(dmem_address), .dmem_wdata(dmem_wdata),
    .dmem_byte_enable(dmem_byte_enable), .MEM_valid(MEM_valid), .MEM_pc(MEM_pc),
    .MEM_alu_out(MEM_alu_out), .MEM_rd(MEM_rd), .MEM_regwrite(MEM_regwrite),
    .MEM_load_data(MEM_load_data), .MEM_misaligned(MEM_misaligned), .MEM_stall(MEM_stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] load_data;
    logic        misaligned;
    logic        regwrite;
    logic        access;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic model_mis(input logic [2:0] f3, input logic [1:0] a);
    if (f3 == 3'b001 || f3 == 3'b101) return a[0];
    if (f3 == 3'b010) return a != 2'd0;
    return 1'b0;
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [1:0] a);
    if (f3[1:0] == 2'b00) begin
      case (a)
        2'd0: return 4'b0001;
        2'd1: return 4'b0010;
        2'd2: return 4'b0100;
        default: return 4'b1000;
      endcase
    end
    if (f3[1:0] == 2'b01) return (a >= 2'd2) ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
    if (f3[1:0] == 2'b00) return {d[7:0], d[7:0], d[7:0], d[7:0]};
    if (f3[1:0] == 2'b01) return {d[15:0], d[15:0]};
    return d;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] a, input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    case (a)
      2'd0: b = d[7:0];
      2'd1: b = d[15:8];
      2'd2: b = d[23:16];
      default: b = d[31:24];
    endcase
    h = a[1] ? d[31:16] : d[15:0];
    case (f3)
      3'b000: return b[7] ? {24'hFFFFFF, b} : {24'h0, b};
      3'b100: return {24'h0, b};
      3'b001: return h[15] ? {16'hFFFF, h} : {16'h0, h};
      3'b101: return {16'h0, h};
      default: return d;
    endcase
  endfunction

  task automatic issue(input logic v, input logic [31:0] pc, input logic [31:0] alu,
                       input logic [31:0] rs2, input logic [4:0] rd, input logic [2:0] f3,
                       input logic mr, input logic mw, input logic rw,
                       input logic [31:0] rdata, input int delay, input logic poke);
    exp_t e, got;
    logic acc;
    acc          = v && (mr || mw);
    e.misaligned = acc && model_mis(f3, alu[1:0]);
    e.regwrite   = v && rw && !e.misaligned;
    e.access     = acc && !e.misaligned;
    e.load_data  = (e.access && mr) ? model_load(f3, alu[1:0], rdata) : 32'h0;
    sb_q.push_back(e);

    @(negedge clk);
    EX_valid = v; EX_pc = pc; EX_alu_out = alu; EX_rs2_out = rs2; EX_rd = rd;
    EX_funct3 = f3; EX_mem_read = mr; EX_mem_write = mw; EX_regwrite = rw; load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    check("cap_pc", MEM_pc, pc);
    check("cap_alu", MEM_alu_out, alu);
    check("cap_valid", MEM_valid, v);
    check("cap_rd", MEM_rd, rd);
    check("cap_ld_clr", MEM_load_data, 32'h0);

    if (e.access) begin
      check("req_stall", MEM_stall, 1'b1);
      check("req_read", dmem_read, mr);
      check("req_write", dmem_write, mw);
      check("req_addr", dmem_address, {alu[31:2], 2'b00});
      if (mw) begin
        check("req_be", dmem_byte_enable, model_be(f3, alu[1:0]));
        check("req_wdata", dmem_wdata, model_wdata(f3, rs2));
      end
      for (int i = 0; i < delay; i++) begin
        @(negedge clk);
        if (poke && i == 0) begin
          EX_pc = pc + 32'h100; EX_alu_out = alu + 32'h10; EX_rd = rd + 5'd1; load = 1'b1;
          @(posedge clk); #1;
          load = 1'b0;
          check("poke_pc", MEM_pc, pc);
          check("poke_rd", MEM_rd, rd);
        end
        check("hold_stall", MEM_stall, 1'b1);
      end
      check("hold_addr", dmem_address, {alu[31:2], 2'b00});
      @(negedge clk);
      dmem_rdata = rdata; dmem_resp = 1'b1;
      @(posedge clk); #1;
      dmem_resp = 1'b0;
    end

    check("done_stall", MEM_stall, 1'b0);
    check("done_rd_req", dmem_read, 1'b0);
    check("done_be", dmem_byte_enable, 4'b0000);
    if (sb_q.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
    end else begin
      got = sb_q.pop_front();
      check("load_data", MEM_load_data, got.load_data);
      check("misaligned", MEM_misaligned, got.misaligned);
      check("regwrite", MEM_regwrite, got.regwrite);
    end
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; EX_valid = 1'b0; EX_pc = '0; EX_alu_out = '0; EX_rs2_out = '0;
    EX_rd = '0; EX_funct3 = '0; EX_mem_read = 1'b0; EX_mem_write = 1'b0; EX_regwrite = 1'b0;
    dmem_rdata = '0; dmem_resp = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_pc", MEM_pc, 32'h0);
    check("rst_stall", MEM_stall, 1'b0);
    check("rst_read", dmem_read, 1'b0);
    reset = 1'b0;

    // Async reset while a load is outstanding, then a stray response.
    @(negedge clk);
    EX_valid = 1'b1; EX_pc = 32'h400; EX_alu_out = 32'h4000; EX_funct3 = 3'b010;
    EX_mem_read = 1'b1; EX_regwrite = 1'b1; load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    check("pre_rst_read", dmem_read, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_read", dmem_read, 1'b0);
    check("mid_rst_stall", MEM_stall, 1'b0);
    check("mid_rst_pc", MEM_pc, 32'h0);
    check("mid_rst_alu", MEM_alu_out, 32'h0);
    check("mid_rst_valid", MEM_valid, 1'b0);
    check("mid_rst_rw", MEM_regwrite, 1'b0);
    #2 reset = 1'b0;
    @(negedge clk);
    dmem_rdata = 32'hCAFE_F00D; dmem_resp = 1'b1;
    @(posedge clk); #1;
    dmem_resp = 1'b0;
    check("stray_resp_ld", MEM_load_data, 32'h0);
    check("stray_resp_stall", MEM_stall, 1'b0);

    //    v     pc        alu           rs2           rd    f3      mr    mw    rw    rdata         dly poke
    issue(1'b1, 32'h10, 32'h0000_1003, 32'h0,        5'd3, 3'b000, 1'b1, 1'b0, 1'b1, 32'h80FF_1234, 1, 1'b0);
    issue(1'b1, 32'h14, 32'h0000_1003, 32'h0,        5'd4, 3'b100, 1'b1, 1'b0, 1'b1, 32'h80FF_1234, 0, 1'b0);
    issue(1'b1, 32'h18, 32'h0000_2002, 32'hDEAD_BEEF, 5'd0, 3'b001, 1'b0, 1'b1, 1'b0, 32'h1111_2222, 2, 1'b0);
    issue(1'b1, 32'h1C, 32'h0000_3001, 32'h0,        5'd6, 3'b010, 1'b1, 1'b0, 1'b1, 32'h0,         0, 1'b0);
    issue(1'b1, 32'h20, 32'h0000_3004, 32'h0,        5'd7, 3'b010, 1'b1, 1'b0, 1'b1, 32'h1234_5678, 3, 1'b1);
    issue(1'b1, 32'h24, 32'h0000_0042, 32'h0,        5'd5, 3'b000, 1'b0, 1'b0, 1'b1, 32'h0,         0, 1'b0);
    issue(1'b0, 32'h28, 32'h0000_5000, 32'h0,        5'd8, 3'b010, 1'b1, 1'b0, 1'b1, 32'h0,         0, 1'b0);
    issue(1'b1, 32'h2C, 32'h0000_5002, 32'h0,        5'd9, 3'b001, 1'b1, 1'b0, 1'b1, 32'h8001_7FFF, 1, 1'b0);
    issue(1'b1, 32'h30, 32'h0000_5000, 32'h0,        5'd9, 3'b101, 1'b1, 1'b0, 1'b1, 32'h8001_7FFF, 0, 1'b0);
    issue(1'b1, 32'h34, 32'h0000_6001, 32'h0000_00A5, 5'd0, 3'b000, 1'b0, 1'b1, 1'b0, 32'h0,         1, 1'b0);
    issue(1'b1, 32'h38, 32'h0000_7000, 32'h0102_0304, 5'd0, 3'b010, 1'b0, 1'b1, 1'b0, 32'h0,         0, 1'b0);
    issue(1'b1, 32'h3C, 32'h0000_7002, 32'h0,        5'd2, 3'b111, 1'b1, 1'b0, 1'b1, 32'hA5A5_0F0F, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- EX/MEM pipeline register plus data-memory access controller; sits directly downstream of the ID/EX register and the ALU.
- Latches EX results and drives the data-memory request/response handshake.
- Stalls the pipeline while an access is outstanding.
- Produces store byte enables and sign/zero-extended load data for the MEM/WB register.

Parameters:
- XLEN, 32, datapath and address width
- REGADDR, 5, register index width

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- load  in  1  pipeline advance; capture EX inputs
- EX_valid  in  1  EX slot holds a real instruction (0 = bubble)
- EX_pc  in  XLEN  instruction PC
- EX_alu_out  in  XLEN  ALU result / effective address
- EX_rs2_out  in  XLEN  store data (already forwarded)
- EX_rd  in  REGADDR  destination register
- EX_funct3  in  3  access size/sign
- EX_mem_read  in  1  load instruction
- EX_mem_write  in  1  store instruction
- EX_regwrite  in  1  writes rd
- dmem_rdata  in  XLEN  memory read data
- dmem_resp  in  1  memory completion pulse
- dmem_read  out  1  read request
- dmem_write  out  1  write request
- dmem_address  out  XLEN  word-aligned address ({MEM_alu_out[31:2],2'b00})
- dmem_wdata  out  XLEN  lane-shifted store data
- dmem_byte_enable  out  4  store lane mask
- MEM_valid  out  1  registered EX_valid
- MEM_pc  out  XLEN  registered PC
- MEM_alu_out  out  XLEN  registered ALU result
- MEM_rd  out  REGADDR  registered rd
- MEM_regwrite  out  1  registered regwrite, forced 0 on bubble or misaligned access
- MEM_load_data  out  XLEN  extended load result
- MEM_misaligned  out  1  captured access misaligned
- MEM_stall  out  1  hold upstream stages

Behaviour:
- Reset (async, immediate):
  - All registered outputs are 0; state is IDLE.
  - dmem_read, dmem_write and MEM_stall go to 0 in the same cycle, including mid-access.
  - A dmem_resp arriving after reset is ignored.
- States:
  - IDLE: no access outstanding.
  - ACCESS: request is asserted.
  - DONE: response captured; outputs are valid.
- Capture:
  - On a rising edge with load=1 and state not ACCESS, every MEM_* register takes its EX_* value.
  - load=1 while in ACCESS is ignored.
  - With load=0 and no response, all registers hold.
- Next state after capture:
  - If EX_valid, (EX_mem_read or EX_mem_write), and the access is aligned: go to ACCESS. Otherwise go to IDLE.
  - MEM_load_data is cleared to 0 on every capture.
- ACCESS:
  - dmem_read = MEM mem_read; dmem_write = MEM mem_write. Both are decoded from registered state only.
  - MEM_stall = 1, combinationally equal to (state==ACCESS).
  - Request is held stable until dmem_resp.
  - On the edge with dmem_resp=1: latch the extended dmem_rdata (loads only; stores leave 0) into MEM_load_data, then go to DONE.
  - Minimum load-to-DONE latency is 2 edges (capture edge, then response edge).
- DONE:
  - MEM_stall = 0 and requests are 0.
  - Holds until the next load capture, which may start a new access in the same edge.
- Alignment, with a = MEM_alu_out[1:0]:
  - Byte accesses: always aligned.
  - Half (funct3 001/101): misaligned if a[0]=1.
  - Word (funct3 010): misaligned if a≠0.
  - Misaligned access: MEM_misaligned=1, no request issued, state IDLE, MEM_regwrite forced 0.
- Store lanes:
  - sb: byte_enable = 4'b0001<<a; wdata = rs2[7:0] replicated ×4.
  - sh: byte_enable = 4'b0011<<(a[1]*2); wdata = rs2[15:0] replicated ×2.
  - sw: byte_enable = 4'b1111; wdata = rs2.
  - byte_enable is 0 when dmem_write=0.
- Load extension:
  - Byte lane is dmem_rdata[8a+7:8a]; half lane is dmem_rdata[16a[1]+15:16a[1]].
  - lb / lh: sign-extend. lbu / lhu: zero-extend. lw: pass through.
  - funct3 011/110/111: treated as lw.
- Bubbles: EX_valid=0 captures as MEM_valid=0, MEM_regwrite=0, no request, even if EX_mem_read=1.
- dmem_resp in IDLE/DONE is ignored.

Test Plan:
- Reset async mid-ACCESS (dmem_read=1) → dmem_read, MEM_stall, all MEM_* fall to 0 before the next clk edge; a later resp is ignored.
- lb at address 0x1003 (funct3 000), dmem_rdata=0x80FF_1234 → dmem_address=0x1000, stall for 1+ cycles, MEM_load_data=0xFFFF_FF80; lbu gives 0x0000_0080.
- sh at 0x2002, rs2=0xDEAD_BEEF → dmem_write=1, byte_enable=4'b1100, wdata=0xBEEF_BEEF; resp → DONE, stall drops, MEM_load_data=0.
- lw at 0x3001 → MEM_misaligned=1, dmem_read never asserted, MEM_stall=0, MEM_regwrite=0.
- load=1 pulsed during ACCESS with new EX values, resp delayed 3 cycles → MEM_* unchanged until resp, DONE reached; next load captures the new instruction.
- Back-to-back ALU op (regwrite=1, rd=5, alu=0x42) then bubble (EX_valid=0, mem_read=1) → first: MEM_alu_out=0x42, no stall; second: MEM_valid=0, MEM_regwrite=0, no request.
